unidade_controle_multiciclo: RTL and testbench

- Control unit for the multicycle processor datapath: registers R0..R7, A, G, IR, adder/subtractor, and the shared 16-bit bus.
- Sequences each instruction through time steps T0..T3 and drives all register load enables, bus-source selects and the ALU mode.
- Returns Done at the final step of each instruction.
- Replaces the inline Tstep/decode logic inside processador_multiciclo; the datapath instantiates this block and feeds back IR and the G-nonzero flag.

---
 rtl/proc_defs.sv | 25 ++
 rtl/dec3to8.sv | 16 +
 rtl/unidade_controle_multiciclo.sv | 143 ++++++++++++++
 tb/tb_unidade_controle_multiciclo.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_defs.sv
// rtl/proc_defs.sv - shared opcode and time-step definitions for the multicycle processor
package proc_defs;

  localparam int NREGS_DEF = 8;
  localparam int SELW_DEF  = 3;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_e;

  // add and sub are the only instructions that use the A/G path and T2/T3
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/dec3to8.sv
// rtl/dec3to8.sv - 3-to-8 one-hot decoder with enable
module dec3to8 (
  input  logic [2:0] w_i,
  input  logic       en_i,
  output logic [7:0] y_o
);

  // one-hot output, all zero when disabled
  always_comb begin
    y_o = 8'h00;
    if (en_i) begin
      y_o[w_i] = 1'b1;
    end
  end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// rtl/unidade_controle_multiciclo.sv - time-step sequencer and decoder for the multicycle datapath
module unidade_controle_multiciclo
  import proc_defs::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int SELW  = SELW_DEF
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Run,
  input  logic [3+2*SELW-1:0]   IR,
  input  logic                  G_nz,
  output logic                  IRin,
  output logic [NREGS-1:0]      Rin,
  output logic [NREGS-1:0]      Rout,
  output logic                  Gout,
  output logic                  DINout,
  output logic                  Ain,
  output logic                  Gin,
  output logic                  AddSub,
  output logic                  Done,
  output logic [1:0]            Tstep
);

  tstep_e tstep_q;
  tstep_e tstep_d;

  logic [2:0] opcode;
  logic [2:0] x_sel;
  logic [2:0] y_sel;
  logic [7:0] x_oh;
  logic [7:0] y_oh;

  // per-step strobes choosing which decoded index reaches Rin/Rout
  logic rin_x;
  logic rout_x;
  logic rout_y;

  assign opcode = IR[3+2*SELW-1:2*SELW];
  assign x_sel  = IR[2*SELW-1:SELW];
  assign y_sel  = IR[SELW-1:0];
  assign Tstep  = tstep_q;

  dec3to8 u_dec_x (
    .w_i  (x_sel),
    .en_i (rin_x | rout_x),
    .y_o  (x_oh)
  );

  dec3to8 u_dec_y (
    .w_i  (y_sel),
    .en_i (rout_y),
    .y_o  (y_oh)
  );

  // time-step register; reset drops straight back to T0 without waiting for a clock
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      tstep_q <= T0;
    end else begin
      tstep_q <= tstep_d;
    end
  end

  // next step and all control outputs from the current step and instruction
  always_comb begin
    tstep_d = T0;
    IRin    = 1'b0;
    rin_x   = 1'b0;
    rout_x  = 1'b0;
    rout_y  = 1'b0;
    Gout    = 1'b0;
    DINout  = 1'b0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    AddSub  = 1'b0;
    Done    = 1'b0;
    case (tstep_q)
      T0: begin
        IRin    = Run;
        tstep_d = Run ? T1 : T0;
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            rout_y = 1'b1;
            rin_x  = 1'b1;
            Done   = 1'b1;
          end
          OP_MVI: begin
            DINout = 1'b1;
            rin_x  = 1'b1;
            Done   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rout_x  = 1'b1;
            Ain     = 1'b1;
            tstep_d = T2;
          end
          OP_MVNZ: begin
            rout_y = G_nz;
            rin_x  = G_nz;
            Done   = 1'b1;
          end
          default: begin
            Done = 1'b1;
          end
        endcase
      end
      T2: begin
        // a non-ALU opcode here means IR changed mid-instruction: idle back to T0
        if (is_alu_op(opcode)) begin
          rout_y  = 1'b1;
          Gin     = 1'b1;
          AddSub  = opcode[0];
          tstep_d = T3;
        end
      end
      T3: begin
        if (is_alu_op(opcode)) begin
          Gout  = 1'b1;
          rin_x = 1'b1;
          Done  = 1'b1;
        end
      end
      default: begin
        tstep_d = T0;
      end
    endcase
  end

  // gate the decoded one-hot selects onto the register enables
  always_comb begin
    Rin  = rin_x ? x_oh : 8'h00;
    Rout = 8'h00;
    if (rout_x) begin
      Rout = x_oh;
    end else if (rout_y) begin
      Rout = y_oh;
    end
  end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// tb/tb_unidade_controle_multiciclo.sv - self-checking bench for unidade_controle_multiciclo
module tb_unidade_controle_multiciclo;

  typedef struct packed {
    logic [1:0] tstep;
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       gout;
    logic       dinout;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic       done;
  } outs_t;

  typedef struct {
    logic       run;
    logic [8:0] ir;
    logic       gnz;
    outs_t      exp;
  } vec_t;

  logic       Clock;
  logic       Resetn;
  logic       Run;
  logic [8:0] IR;
  logic       G_nz;
  logic       IRin;
  logic [7:0] Rin;
  logic [7:0] Rout;
  logic       Gout;
  logic       DINout;
  logic       Ain;
  logic       Gin;
  logic       AddSub;
  logic       Done;
  logic [1:0] Tstep;

  int checks;
  int errors;

  outs_t act;
  assign act = {Tstep, IRin, Rin, Rout, Gout, DINout, Ain, Gin, AddSub, Done};

  unidade_controle_multiciclo dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Run    (Run),
    .IR     (IR),
    .G_nz   (G_nz),
    .IRin   (IRin),
    .Rin    (Rin),
    .Rout   (Rout),
    .Gout   (Gout),
    .DINout (DINout),
    .Ain    (Ain),
    .Gin    (Gin),
    .AddSub (AddSub),
    .Done   (Done),
    .Tstep  (Tstep)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // flags = {gout, dinout, ain, gin, addsub, done}
  function automatic outs_t mk(int ts, int irin, int rin, int rout, int flags);
    outs_t o;
    o.tstep  = 2'(ts);
    o.irin   = 1'(irin);
    o.rin    = 8'(rin);
    o.rout   = 8'(rout);
    o.gout   = flags[5];
    o.dinout = flags[4];
    o.ain    = flags[3];
    o.gin    = flags[2];
    o.addsub = flags[1];
    o.done   = flags[0];
    return o;
  endfunction

  // reference: cycle k of an instruction (k=0 is the fetch cycle)
  function automatic outs_t model(int k, logic [8:0] ir, logic run, logic gnz);
    outs_t o;
    int op;
    int xo;
    int yo;
    op = int'(ir[8:6]);
    xo = 1 << int'(ir[5:3]);
    yo = 1 << int'(ir[2:0]);
    o = mk(k, 0, 0, 0, 0);
    if (k == 0) o.irin = run;
    else if (k == 1) begin
      if (op == 0)                o = mk(1, 0, xo, yo, 'b000001);
      else if (op == 1)           o = mk(1, 0, xo, 0,  'b010001);
      else if (op == 2 || op == 3) o = mk(1, 0, 0, xo, 'b001000);
      else if (op == 4 && gnz)    o = mk(1, 0, xo, yo, 'b000001);
      else                        o = mk(1, 0, 0, 0,   'b000001);
    end else if (k == 2) o = mk(2, 0, 0, yo, (op == 3) ? 'b000110 : 'b000100);
    else                 o = mk(3, 0, xo, 0, 'b100001);
    return o;
  endfunction

  function automatic int instr_len(logic [8:0] ir);
    return (ir[8:6] == 3'b010 || ir[8:6] == 3'b011) ? 4 : 2;
  endfunction

  task automatic check(string name, outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_inv(string name);
    checks++;
    if (($countones(Rout) + int'(Gout) + int'(DINout)) > 1 ||
        $countones(Rin) > 1 || $countones(Rout) > 1) begin
      errors++;
      $display("FAIL %s: invariant Rout=%b Gout=%b DINout=%b Rin=%b required at most one bus driver, one-hot enables",
               name, Rout, Gout, DINout, Rin);
    end
  endtask

  // apply just after a rising edge, sample on the falling edge, then advance
  task automatic cycle(logic run, logic [8:0] ir, logic gnz, outs_t exp, string name);
    Run  = run;
    IR   = ir;
    G_nz = gnz;
    @(negedge Clock);
    check(name, exp);
    check_inv(name);
    @(posedge Clock);
    #1;
  endtask

  vec_t tbl[23];

  initial begin
    int k;
    int dones;
    int instrs;
    logic [8:0] cur_ir;
    logic run_r;
    logic gnz_r;
    checks = 0;
    errors = 0;

    tbl[0]  = '{1'b1, 9'b000_000_001, 1'b0, mk(0, 1, 0, 0, 'b000000)};
    tbl[1]  = '{1'b0, 9'b000_000_001, 1'b0, mk(1, 0, 'h01, 'h02, 'b000001)};
    tbl[2]  = '{1'b1, 9'b001_011_000, 1'b0, mk(0, 1, 0, 0, 'b000000)};
    tbl[3]  = '{1'b0, 9'b001_011_000, 1'b0, mk(1, 0, 'h08, 0, 'b010001)};
    tbl[4]  = '{1'b1, 9'b011_001_000, 1'b0, mk(0, 1, 0, 0, 'b000000)};
    tbl[5]  = '{1'b1, 9'b011_001_000, 1'b0, mk(1, 0, 0, 'h02, 'b001000)};
    tbl[6]  = '{1'b0, 9'b011_001_000, 1'b0, mk(2, 0, 0, 'h01, 'b000110)};
    tbl[7]  = '{1'b0, 9'b011_001_000, 1'b0, mk(3, 0, 'h02, 0, 'b100001)};
    tbl[8]  = '{1'b0, 9'b011_001_000, 1'b0, mk(0, 0, 0, 0, 'b000000)};
    tbl[9]  = '{1'b1, 9'b010_001_000, 1'b0, mk(0, 1, 0, 0, 'b000000)};
    tbl[10] = '{1'b0, 9'b010_001_000, 1'b0, mk(1, 0, 0, 'h02, 'b001000)};
    tbl[11] = '{1'b0, 9'b010_001_000, 1'b0, mk(2, 0, 0, 'h01, 'b000100)};
    tbl[12] = '{1'b0, 9'b010_001_000, 1'b0, mk(3, 0, 'h02, 0, 'b100001)};
    tbl[13] = '{1'b1, 9'b100_000_001, 1'b0, mk(0, 1, 0, 0, 'b000000)};
    tbl[14] = '{1'b0, 9'b100_000_001, 1'b0, mk(1, 0, 0, 0, 'b000001)};
    tbl[15] = '{1'b1, 9'b100_000_001, 1'b1, mk(0, 1, 0, 0, 'b000000)};
    tbl[16] = '{1'b1, 9'b100_000_001, 1'b1, mk(1, 0, 'h01, 'h02, 'b000001)};
    tbl[17] = '{1'b1, 9'b111_010_101, 1'b0, mk(0, 1, 0, 0, 'b000000)};
    tbl[18] = '{1'b0, 9'b111_010_101, 1'b0, mk(1, 0, 0, 0, 'b000001)};
    tbl[19] = '{1'b1, 9'b011_010_010, 1'b0, mk(0, 1, 0, 0, 'b000000)};
    tbl[20] = '{1'b0, 9'b011_010_010, 1'b0, mk(1, 0, 0, 'h04, 'b001000)};
    tbl[21] = '{1'b0, 9'b011_010_010, 1'b0, mk(2, 0, 0, 'h04, 'b000110)};
    tbl[22] = '{1'b0, 9'b011_010_010, 1'b0, mk(3, 0, 'h04, 0, 'b100001)};

    // reset held with Run high, checked before any clock edge
    Resetn = 1'b0;
    Run    = 1'b1;
    IR     = 9'b010_001_000;
    G_nz   = 1'b0;
    #3;
    check("reset_async", mk(0, 1, 0, 0, 'b000000));
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("reset_held", mk(0, 1, 0, 0, 'b000000));
    @(posedge Clock);
    #1;
    Resetn = 1'b1;

    foreach (tbl[i]) begin
      cycle(tbl[i].run, tbl[i].ir, tbl[i].gnz, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // reset pulsed mid-cycle in T2 of add: immediate T0, Gin drops, no Done
    cycle(1'b1, 9'b010_011_100, 1'b0, mk(0, 1, 0, 0, 'b000000), "rst_t2_fetch");
    cycle(1'b0, 9'b010_011_100, 1'b0, mk(1, 0, 0, 'h08, 'b001000), "rst_t2_t1");
    @(negedge Clock);
    check("rst_t2_t2", mk(2, 0, 0, 'h10, 'b000100));
    #2;
    Resetn = 1'b0;
    #1;
    check("rst_t2_async", mk(0, 0, 0, 0, 'b000000));
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    @(negedge Clock);
    check("rst_t2_after", mk(0, 0, 0, 0, 'b000000));
    @(posedge Clock);
    #1;

    // IR corrupted to mv while in T2: all outputs low, back to T0
    cycle(1'b1, 9'b011_001_000, 1'b0, mk(0, 1, 0, 0, 'b000000), "corrupt_fetch");
    cycle(1'b0, 9'b011_001_000, 1'b0, mk(1, 0, 0, 'h02, 'b001000), "corrupt_t1");
    cycle(1'b0, 9'b000_001_010, 1'b0, mk(2, 0, 0, 0, 'b000000), "corrupt_t2");
    cycle(1'b0, 9'b000_001_010, 1'b0, mk(0, 0, 0, 0, 'b000000), "corrupt_back");

    // randomized run against the instruction-level model
    k      = 0;
    dones  = 0;
    instrs = 0;
    cur_ir = 9'd0;
    for (int n = 0; n < 3000; n++) begin
      if (k == 0) cur_ir = 9'($urandom);
      run_r = ($urandom_range(0, 9) < 7);
      gnz_r = 1'($urandom);
      Run  = run_r;
      IR   = cur_ir;
      G_nz = gnz_r;
      @(negedge Clock);
      check($sformatf("rand%0d", n), model(k, cur_ir, run_r, gnz_r));
      check_inv($sformatf("rand_inv%0d", n));
      if (Done === 1'b1) dones++;
      if (k == 0) begin
        if (run_r) begin
          k = 1;
          instrs++;
        end
      end else if (k == instr_len(cur_ir) - 1) begin
        k = 0;
      end else begin
        k = k + 1;
      end
      @(posedge Clock);
      #1;
    end
    // the last instruction may still be in flight
    checks++;
    if (dones != instrs && dones != instrs - 1) begin
      errors++;
      $display("FAIL done_count: actual=%0d required=%0d", dones, instrs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
